// File: rtl/wave_classifier.sv
// Classifies a 5-bit sample stream per window as square/sawtooth/triangle/unknown
// and tracks the period between zero entries plus peak/trough per window.
module wave_classifier #(
    parameter int WIN = 64,
    parameter int PW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    input  logic          sample_valid,
    input  logic [4:0]    sample,
    output logic          result_valid,
    output logic [1:0]    wave_type,
    output logic [PW-1:0] period,
    output logic [4:0]    peak,
    output logic [4:0]    trough,
    output logic          period_ovf
);

    localparam logic [PW-1:0] PMAX     = {PW{1'b1}};
    localparam logic [PW-1:0] PONE     = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PZERO    = {PW{1'b0}};
    localparam logic [7:0]    WIN_LAST = 8'(WIN - 1);

    logic [7:0]    win_cnt_r;
    logic [4:0]    prev_r;
    logic          prev_valid_r;
    logic          hold_r, up1_r, dn1_r, jup_r, jdn_r;
    logic [4:0]    pk_r, tr_r;
    logic [PW-1:0] pcnt_r;
    logic          zero_seen_r;
    logic          ovf_pend_r;
    logic [PW-1:0] per_meas_r;

    logic          accept_s, dv_s, win_last_s, first_s, zero_entry_s, ovf_s;
    logic signed [5:0] delta_s;
    logic          hold_nxt_s, up1_nxt_s, dn1_nxt_s, jup_nxt_s, jdn_nxt_s;
    logic [4:0]    pk_nxt_s, tr_nxt_s;
    logic [PW-1:0] per_nxt_s;

    function automatic logic [1:0] classify(input logic hold, input logic up1,
                                            input logic dn1, input logic jup,
                                            input logic jdn);
        if (up1 && dn1 && !jup && !jdn && !hold) begin
            return 2'b10;
        end else if (up1 && jdn && !dn1 && !jup && !hold) begin
            return 2'b01;
        end else if (hold && jup && jdn && !up1 && !dn1) begin
            return 2'b00;
        end else begin
            return 2'b11;
        end
    endfunction

    // Next-state view of flags, trackers and period measurement for the current sample
    always_comb begin
        accept_s     = sample_valid && !restart;
        delta_s      = {1'b0, sample} - {1'b0, prev_r};
        dv_s         = accept_s && prev_valid_r;
        win_last_s   = accept_s && (win_cnt_r == WIN_LAST);
        first_s      = (win_cnt_r == 8'd0);
        hold_nxt_s   = hold_r | (dv_s && (delta_s == 6'sd0));
        up1_nxt_s    = up1_r  | (dv_s && (delta_s == 6'sd1));
        dn1_nxt_s    = dn1_r  | (dv_s && (delta_s == -6'sd1));
        jup_nxt_s    = jup_r  | (dv_s && (delta_s > 6'sd1));
        jdn_nxt_s    = jdn_r  | (dv_s && (delta_s < -6'sd1));
        pk_nxt_s     = (first_s || (sample > pk_r)) ? sample : pk_r;
        tr_nxt_s     = (first_s || (sample < tr_r)) ? sample : tr_r;
        zero_entry_s = dv_s && (sample == 5'd0) && (prev_r != 5'd0);
        // A counter sitting at max would wrap on +1, so it counts as overflow too
        ovf_s        = ovf_pend_r || (pcnt_r == PMAX);
        if (zero_entry_s && zero_seen_r) begin
            if (ovf_s) begin
                per_nxt_s = PMAX;
            end else begin
                per_nxt_s = pcnt_r + PONE;
            end
        end else begin
            per_nxt_s = per_meas_r;
        end
    end

    // State update, window closing and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r    <= 8'd0;
            prev_r       <= 5'd0;
            prev_valid_r <= 1'b0;
            hold_r       <= 1'b0;
            up1_r        <= 1'b0;
            dn1_r        <= 1'b0;
            jup_r        <= 1'b0;
            jdn_r        <= 1'b0;
            pk_r         <= 5'd0;
            tr_r         <= 5'd0;
            pcnt_r       <= PZERO;
            zero_seen_r  <= 1'b0;
            ovf_pend_r   <= 1'b0;
            per_meas_r   <= PZERO;
            result_valid <= 1'b0;
            wave_type    <= 2'b11;
            period       <= PZERO;
            peak         <= 5'd0;
            trough       <= 5'd0;
            period_ovf   <= 1'b0;
        end else if (restart) begin
            win_cnt_r    <= 8'd0;
            prev_valid_r <= 1'b0;
            hold_r       <= 1'b0;
            up1_r        <= 1'b0;
            dn1_r        <= 1'b0;
            jup_r        <= 1'b0;
            jdn_r        <= 1'b0;
            pk_r         <= 5'd0;
            tr_r         <= 5'd0;
            pcnt_r       <= PZERO;
            zero_seen_r  <= 1'b0;
            ovf_pend_r   <= 1'b0;
            per_meas_r   <= PZERO;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (accept_s) begin
                prev_r       <= sample;
                prev_valid_r <= 1'b1;
                per_meas_r   <= per_nxt_s;
                if (zero_entry_s) begin
                    pcnt_r      <= PZERO;
                    zero_seen_r <= 1'b1;
                    period_ovf  <= ovf_s;
                    ovf_pend_r  <= 1'b0;
                end else if (pcnt_r == PMAX) begin
                    ovf_pend_r  <= 1'b1;
                end else begin
                    pcnt_r      <= pcnt_r + PONE;
                end
                if (win_last_s) begin
                    result_valid <= 1'b1;
                    wave_type    <= classify(hold_nxt_s, up1_nxt_s, dn1_nxt_s,
                                             jup_nxt_s, jdn_nxt_s);
                    peak         <= pk_nxt_s;
                    trough       <= tr_nxt_s;
                    period       <= per_nxt_s;
                    win_cnt_r    <= 8'd0;
                    hold_r       <= 1'b0;
                    up1_r        <= 1'b0;
                    dn1_r        <= 1'b0;
                    jup_r        <= 1'b0;
                    jdn_r        <= 1'b0;
                    pk_r         <= 5'd0;
                    tr_r         <= 5'd0;
                end else begin
                    win_cnt_r    <= win_cnt_r + 8'd1;
                    hold_r       <= hold_nxt_s;
                    up1_r        <= up1_nxt_s;
                    dn1_r        <= dn1_nxt_s;
                    jup_r        <= jup_nxt_s;
                    jdn_r        <= jdn_nxt_s;
                    pk_r         <= pk_nxt_s;
                    tr_r         <= tr_nxt_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_classifier.sv
// Directed bench for wave_classifier: square, sawtooth, triangle, constant,
// restart, period overflow and asynchronous reset mid-window.
module tb_wave_classifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic       sample_valid;
    logic [4:0] sample;
    logic       result_valid;
    logic [1:0] wave_type;
    logic [7:0] period;
    logic [4:0] peak;
    logic [4:0] trough;
    logic       period_ovf;

    int checks = 0;
    int errors = 0;
    int rv_cnt = 0;
    int base   = 0;

    wave_classifier #(.WIN(64), .PW(8)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .sample_valid(sample_valid), .sample(sample),
        .result_valid(result_valid), .wave_type(wave_type), .period(period),
        .peak(peak), .trough(trough), .period_ovf(period_ovf)
    );

    always #5 clk = ~clk;

    // Counts result pulses; reads the value held before this edge
    always @(posedge clk) begin
        if (result_valid === 1'b1) rv_cnt <= rv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] v);
        @(negedge clk);
        sample_valid = 1'b1;
        sample       = v;
    endtask

    task automatic idle();
        @(negedge clk);
        sample_valid = 1'b0;
        restart      = 1'b0;
    endtask

    task automatic do_restart(input logic v);
        @(negedge clk);
        restart      = 1'b1;
        sample_valid = v;
        sample       = 5'd9;
        @(negedge clk);
        restart      = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rv"},     {31'd0, result_valid}, 32'd0);
        chk({tag, "_type"},   {30'd0, wave_type},    32'd3);
        chk({tag, "_period"}, {24'd0, period},       32'd0);
        chk({tag, "_peak"},   {27'd0, peak},         32'd0);
        chk({tag, "_trough"}, {27'd0, trough},       32'd0);
        chk({tag, "_ovf"},    {31'd0, period_ovf},   32'd0);
    endtask

    function automatic logic [4:0] sq(input int i);
        return (((i / 10) % 2) == 1) ? 5'd20 : 5'd0;
    endfunction

    function automatic logic [4:0] saw(input int i);
        return 5'(i % 21);
    endfunction

    function automatic logic [4:0] tri_w(input int i);
        int p;
        p = i % 40;
        return (p <= 20) ? 5'(p) : 5'(40 - p);
    endfunction

    function automatic logic [4:0] ovf_w(input int i);
        if (i < 5) return 5'd20;
        else if (i < 10) return 5'd0;
        else if (i < 310) return 5'd20;
        else return 5'd0;
    endfunction

    initial begin
        rst_n = 1'b0; restart = 1'b0; sample_valid = 1'b0; sample = 5'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Square
        base = rv_cnt;
        for (int i = 0; i < 64; i++) send(sq(i));
        idle();
        chk("sq_rv", {31'd0, result_valid}, 32'd1);
        chk("sq_type", {30'd0, wave_type}, 32'd0);
        chk("sq_period", {24'd0, period}, 32'd20);
        chk("sq_peak", {27'd0, peak}, 32'd20);
        chk("sq_trough", {27'd0, trough}, 32'd0);
        chk("sq_ovf", {31'd0, period_ovf}, 32'd0);
        idle();
        chk("sq_pulse_end", {31'd0, result_valid}, 32'd0);
        chk("sq_count", 32'(rv_cnt - base), 32'd1);

        // Sawtooth
        do_restart(1'b0);
        for (int i = 0; i < 64; i++) send(saw(i));
        idle();
        chk("saw_rv", {31'd0, result_valid}, 32'd1);
        chk("saw_type", {30'd0, wave_type}, 32'd1);
        chk("saw_period", {24'd0, period}, 32'd21);
        chk("saw_peak", {27'd0, peak}, 32'd20);
        chk("saw_trough", {27'd0, trough}, 32'd0);

        // Triangle, two windows
        do_restart(1'b0);
        for (int i = 0; i < 64; i++) send(tri_w(i));
        idle();
        chk("tri1_rv", {31'd0, result_valid}, 32'd1);
        chk("tri1_type", {30'd0, wave_type}, 32'd2);
        chk("tri1_period", {24'd0, period}, 32'd0);
        for (int i = 64; i < 128; i++) send(tri_w(i));
        idle();
        chk("tri2_rv", {31'd0, result_valid}, 32'd1);
        chk("tri2_type", {30'd0, wave_type}, 32'd2);
        chk("tri2_period", {24'd0, period}, 32'd40);
        chk("tri2_peak", {27'd0, peak}, 32'd20);
        chk("tri2_trough", {27'd0, trough}, 32'd0);

        // Constant with valid toggling every other cycle
        do_restart(1'b0);
        base = rv_cnt;
        for (int i = 0; i < 64; i++) begin
            send(5'd7);
            if (i < 63) idle();
        end
        idle();
        chk("const_rv", {31'd0, result_valid}, 32'd1);
        chk("const_type", {30'd0, wave_type}, 32'd3);
        chk("const_peak", {27'd0, peak}, 32'd7);
        chk("const_trough", {27'd0, trough}, 32'd7);
        chk("const_period", {24'd0, period}, 32'd0);
        idle();
        chk("const_count", 32'(rv_cnt - base), 32'd1);

        // Restart with a valid sample in the same cycle
        do_restart(1'b0);
        base = rv_cnt;
        for (int i = 0; i < 30; i++) send(saw(i));
        do_restart(1'b1);
        for (int i = 0; i < 63; i++) send(saw(i));
        idle();
        chk("rst_63_rv", {31'd0, result_valid}, 32'd0);
        idle();
        chk("rst_63_count", 32'(rv_cnt - base), 32'd0);
        send(saw(63));
        idle();
        chk("rst_64_rv", {31'd0, result_valid}, 32'd1);
        chk("rst_64_type", {30'd0, wave_type}, 32'd1);
        chk("rst_64_period", {24'd0, period}, 32'd21);
        idle();
        chk("rst_count", 32'(rv_cnt - base), 32'd1);

        // Period counter overflow
        do_restart(1'b0);
        for (int i = 0; i <= 310; i++) send(ovf_w(i));
        idle();
        chk("ovf_flag_at_entry", {31'd0, period_ovf}, 32'd1);
        for (int i = 311; i < 320; i++) send(ovf_w(i));
        idle();
        chk("ovf_rv", {31'd0, result_valid}, 32'd1);
        chk("ovf_period", {24'd0, period}, 32'd255);
        chk("ovf_flag", {31'd0, period_ovf}, 32'd1);
        chk("ovf_type", {30'd0, wave_type}, 32'd3);
        chk("ovf_peak", {27'd0, peak}, 32'd20);

        // Asynchronous reset mid-window
        for (int i = 0; i < 20; i++) send(sq(i));
        @(negedge clk);
        sample_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        base = rv_cnt;
        for (int i = 0; i < 63; i++) send(saw(i));
        idle();
        chk("midrst_63_rv", {31'd0, result_valid}, 32'd0);
        idle();
        chk("midrst_63_count", 32'(rv_cnt - base), 32'd0);
        send(saw(63));
        idle();
        chk("midrst_64_rv", {31'd0, result_valid}, 32'd1);
        chk("midrst_64_type", {30'd0, wave_type}, 32'd1);
        chk("midrst_64_period", {24'd0, period}, 32'd21);
        chk("midrst_64_trough", {27'd0, trough}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
